// File: rtl/irq_dispatch.sv
// SM83 interrupt flag/enable unit: IF/IE/IME storage, delayed EI, and the
// 5 M-cycle dispatch sequencer that drives PC push strobes and vector bits.
module irq_dispatch #(
   parameter int NIRQ = 5
) (
   input  logic            CLK,
   input  logic            nRES,
   input  logic            mstep,
   input  logic [NIRQ-1:0] irq,
   input  logic            reg_wr,
   input  logic            reg_rd,
   input  logic            reg_sel,
   input  logic [7:0]      DL_in,
   output logic [7:0]      DL_out,
   input  logic            ei,
   input  logic            di,
   input  logic            reti,
   input  logic            fetch,
   input  logic            int_ack,
   output logic            int_req,
   output logic            halt_wake,
   output logic            ime,
   output logic            dsp_busy,
   output logic            push_h,
   output logic            push_l,
   output logic            load_vec,
   output logic [7:3]      bro,
   output logic [2:0]      dbg_state
);

   // Handshake: int_req is offered only in IDLE; a step with mstep & int_ack & int_req commits the dispatch.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WAIT1  = 3'd1,
      S_WAIT2  = 3'd2,
      S_PUSH_H = 3'd3,
      S_PUSH_L = 3'd4,
      S_JUMP   = 3'd5
   } state_t;

   state_t          state_q;
   logic [NIRQ-1:0] if_q, if_d, clr;
   logic [7:0]      ie_q;
   logic            ime_q, ime_d;
   logic            ei_pend_q, ei_pend_d;
   logic            ei_cnt_q, ei_cnt_d;
   logic [2:0]      vsel_q, vsel_d;
   logic            vvalid_q;
   logic            push_h_q, push_l_q, load_vec_q, busy_q;
   logic [NIRQ-1:0] pend;
   logic            ack_take;

   assign pend      = if_q & ie_q[NIRQ-1:0];
   assign halt_wake = |pend;
   assign int_req   = ime_q & (|pend) & (state_q == S_IDLE) & ~ei_pend_q;
   assign ack_take  = mstep & int_ack & int_req;
   assign ime       = ime_q;
   assign push_h    = push_h_q;
   assign push_l    = push_l_q;
   assign load_vec  = load_vec_q;
   assign dsp_busy  = busy_q;
   assign bro       = (load_vec_q && vvalid_q) ? {2'b01, vsel_q} : 5'b00000;
   assign dbg_state = state_q;

   always_comb begin
      DL_out = 8'h00;
      if (reg_rd) DL_out = reg_sel ? ie_q : {{(8-NIRQ){1'b1}}, if_q};
   end

   // Lowest index wins; evaluated against live IF/IE so late IE writes cancel.
   always_comb begin
      vsel_d = 3'd0;
      for (int i = NIRQ - 1; i >= 0; i--) begin
         if (pend[i]) vsel_d = 3'(i);
      end
   end

   always_comb begin
      clr = '0;
      if (state_q == S_JUMP && mstep && vvalid_q) clr[vsel_q] = 1'b1;
      if_d = if_q & ~clr;
      if (reg_wr && !reg_sel) if_d = DL_in[NIRQ-1:0];
      if_d = if_d | irq;
   end

   // ei arms a two-fetch countdown: the fetch ending EI, then the one ending the next instruction.
   always_comb begin
      ime_d     = ime_q;
      ei_pend_d = ei_pend_q;
      ei_cnt_d  = ei_cnt_q;
      if (mstep) begin
         if (ei) begin
            ei_pend_d = 1'b1;
            ei_cnt_d  = 1'b0;
         end else if (fetch && ei_pend_q) begin
            if (ei_cnt_q) begin
               ime_d     = 1'b1;
               ei_pend_d = 1'b0;
               ei_cnt_d  = 1'b0;
            end else begin
               ei_cnt_d = 1'b1;
            end
         end
         if (reti) ime_d = 1'b1;
         if (ack_take) ime_d = 1'b0;
         if (di) begin
            ime_d     = 1'b0;
            ei_pend_d = 1'b0;
            ei_cnt_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRES) begin
         if_q      <= '0;
         ie_q      <= 8'h00;
         ime_q     <= 1'b0;
         ei_pend_q <= 1'b0;
         ei_cnt_q  <= 1'b0;
      end else begin
         if_q      <= if_d;
         ime_q     <= ime_d;
         ei_pend_q <= ei_pend_d;
         ei_cnt_q  <= ei_cnt_d;
         if (reg_wr && reg_sel) ie_q <= DL_in;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRES) begin
         state_q    <= S_IDLE;
         vsel_q     <= 3'd0;
         vvalid_q   <= 1'b0;
         push_h_q   <= 1'b0;
         push_l_q   <= 1'b0;
         load_vec_q <= 1'b0;
         busy_q     <= 1'b0;
      end else if (mstep) begin
         case (state_q)
            S_IDLE: begin
               if (ack_take) begin
                  state_q <= S_WAIT1;
                  busy_q  <= 1'b1;
               end
            end
            S_WAIT1: state_q <= S_WAIT2;
            S_WAIT2: begin
               state_q  <= S_PUSH_H;
               push_h_q <= 1'b1;
            end
            S_PUSH_H: begin
               state_q  <= S_PUSH_L;
               push_h_q <= 1'b0;
               push_l_q <= 1'b1;
               vsel_q   <= vsel_d;
               vvalid_q <= |pend;
            end
            S_PUSH_L: begin
               state_q    <= S_JUMP;
               push_l_q   <= 1'b0;
               load_vec_q <= 1'b1;
            end
            S_JUMP: begin
               state_q    <= S_IDLE;
               load_vec_q <= 1'b0;
               busy_q     <= 1'b0;
            end
            default: begin
               state_q    <= S_IDLE;
               push_h_q   <= 1'b0;
               push_l_q   <= 1'b0;
               load_vec_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_dispatch.sv
// Bench for irq_dispatch: register table, directed dispatch/EI sequences and
// randomized traffic against a phase-counting reference model.
module tb_irq_dispatch;

   logic       CLK = 1'b0;
   logic       nRES, mstep, reg_wr, reg_rd, reg_sel;
   logic [4:0] irq;
   logic [7:0] DL_in, DL_out;
   logic       ei, di, reti, fetch, int_ack;
   logic       int_req, halt_wake, ime, dsp_busy, push_h, push_l, load_vec;
   logic [7:3] bro;
   logic [2:0] dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [4:0] if_m;
   logic [7:0] ie_m;
   logic       ime_m;
   int         eip_m;    // fetches still needed before IME rises
   int         phase_m;  // 0 idle, 1..5 = dispatch M-cycle index
   int         vec_m;    // -1 when no vector chosen
   logic [4:0] exp_q[$];
   logic       prev_lv = 1'b0;

   typedef struct {
      logic       wr;
      logic       sel;
      logic       rd;
      logic [7:0] dl;
      logic [4:0] irq_v;
      logic [7:0] exp_dl;
   } vec_t;
   vec_t tbl[9];

   irq_dispatch #(.NIRQ(5)) dut (
      .CLK(CLK), .nRES(nRES), .mstep(mstep), .irq(irq),
      .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_sel(reg_sel),
      .DL_in(DL_in), .DL_out(DL_out),
      .ei(ei), .di(di), .reti(reti), .fetch(fetch), .int_ack(int_ack),
      .int_req(int_req), .halt_wake(halt_wake), .ime(ime), .dsp_busy(dsp_busy),
      .push_h(push_h), .push_l(push_l), .load_vec(load_vec), .bro(bro),
      .dbg_state(dbg_state)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      if_m    = 5'h00;
      ie_m    = 8'h00;
      ime_m   = 1'b0;
      eip_m   = 0;
      phase_m = 0;
      vec_m   = -1;
   endtask

   function automatic logic model_req();
      return ime_m && ((if_m & ie_m[4:0]) != 5'h00) && phase_m == 0 && eip_m == 0;
   endfunction

   task automatic model_step();
      logic [4:0] pend, nif;
      logic       req;
      int         lowest;
      if (!nRES) begin
         model_reset();
         return;
      end
      pend = if_m & ie_m[4:0];
      req  = model_req();
      nif  = if_m;
      if (reg_wr && !reg_sel) nif = DL_in[4:0];
      else if (phase_m == 5 && mstep && vec_m >= 0) nif = if_m & ~5'(1 << vec_m);
      nif = nif | irq;
      if (reg_wr && reg_sel) ie_m = DL_in;
      if (mstep) begin
         if (phase_m == 3) begin
            lowest = -1;
            for (int b = 4; b >= 0; b--) if (pend[b]) lowest = b;
            vec_m = lowest;
         end
         if (phase_m == 4) exp_q.push_back(vec_m >= 0 ? {2'b01, 3'(vec_m)} : 5'b00000);
         if (phase_m == 0) begin
            if (int_ack && req) phase_m = 1;
         end else if (phase_m == 5) phase_m = 0;
         else phase_m = phase_m + 1;
         if (ei) eip_m = 2;
         else if (fetch && eip_m > 0) begin
            eip_m = eip_m - 1;
            if (eip_m == 0) ime_m = 1'b1;
         end
         if (reti) ime_m = 1'b1;
         if (int_ack && req) ime_m = 1'b0;
         if (di) begin
            ime_m = 1'b0;
            eip_m = 0;
         end
      end
      if_m = nif;
   endtask

   task automatic compare_all();
      logic [4:0] pend;
      logic [7:0] exp_dl;
      logic [4:0] exp_bro, e;
      pend    = if_m & ie_m[4:0];
      exp_dl  = !reg_rd ? 8'h00 : (reg_sel ? ie_m : {3'b111, if_m});
      exp_bro = (phase_m == 5 && vec_m >= 0) ? {2'b01, 3'(vec_m)} : 5'b00000;
      chk("int_req",   32'(int_req),   32'(model_req()));
      chk("halt_wake", 32'(halt_wake), 32'(pend != 5'h00));
      chk("ime",       32'(ime),       32'(ime_m));
      chk("dsp_busy",  32'(dsp_busy),  32'(phase_m != 0));
      chk("push_h",    32'(push_h),    32'(phase_m == 3));
      chk("push_l",    32'(push_l),    32'(phase_m == 4));
      chk("load_vec",  32'(load_vec),  32'(phase_m == 5));
      chk("bro",       32'(bro),       32'(exp_bro));
      chk("DL_out",    32'(DL_out),    32'(exp_dl));
      if (load_vec && !prev_lv) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_bro", 32'(bro), 32'(e));
         end else begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected at %0t: got load_vec with bro %0h, expected no dispatch", $time, bro);
         end
      end
      prev_lv = load_vec;
   endtask

   task automatic tick();
      model_step();
      @(posedge CLK);
      #1;
      compare_all();
   endtask

   task automatic clr();
      nRES = 1'b1; mstep = 1'b1; irq = 5'h00;
      reg_wr = 1'b0; reg_rd = 1'b0; reg_sel = 1'b0; DL_in = 8'h00;
      ei = 1'b0; di = 1'b0; reti = 1'b0; fetch = 1'b0; int_ack = 1'b0;
   endtask

   task automatic do_reset();
      clr(); nRES = 1'b0; tick(); tick(); clr();
   endtask

   task automatic wr(input logic sel, input logic [7:0] d);
      clr(); reg_wr = 1'b1; reg_sel = sel; DL_in = d; tick();
   endtask

   task automatic rd(input logic sel);
      clr(); reg_rd = 1'b1; reg_sel = sel; tick();
   endtask

   task automatic idle(input int n);
      clr();
      repeat (n) tick();
   endtask

   initial begin
      tbl[0] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'b00000, 8'hE0};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 8'hE2, 5'b00000, 8'h00};
      tbl[2] = '{1'b0, 1'b1, 1'b1, 8'h00, 5'b00000, 8'hE2};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h1F, 5'b00000, 8'h00};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'b00000, 8'hFF};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 5'b00010, 8'h00};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'b00000, 8'hE2};
      tbl[7] = '{1'b1, 1'b0, 1'b0, 8'hE0, 5'b00000, 8'h00};
      tbl[8] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'b00001, 8'hE1};

      model_reset();
      do_reset();

      // register access table, including the irq/write collision
      foreach (tbl[i]) begin
         clr();
         reg_wr = tbl[i].wr; reg_sel = tbl[i].sel; reg_rd = tbl[i].rd;
         DL_in = tbl[i].dl; irq = tbl[i].irq_v;
         tick();
         chk($sformatf("tbl%0d_dl", i), 32'(DL_out), 32'(tbl[i].exp_dl));
         if (i == 6) begin
            chk("coll_halt_wake", 32'(halt_wake), 32'd1);
            chk("coll_int_req",   32'(int_req),   32'd0);
         end
      end

      // priority: Timer and Joypad pending, Timer wins
      do_reset();
      wr(1'b1, 8'h1F);
      clr(); reti = 1'b1; tick();
      clr(); irq = 5'b10100; tick();
      chk("prio_req", 32'(int_req), 32'd1);
      clr(); int_ack = 1'b1; tick();
      chk("prio_ime_clr", 32'(ime), 32'd0);
      idle(4);
      chk("prio_lv", 32'(load_vec), 32'd1);
      chk("prio_bro", 32'(bro), 32'h0A);
      rd(1'b0);
      chk("prio_if", 32'(DL_out), 32'hF0);

      // EI delay and DI interactions
      do_reset();
      clr(); ei = 1'b1; tick();
      clr(); fetch = 1'b1; tick();
      chk("ei_fetch1", 32'(ime), 32'd0);
      clr(); fetch = 1'b1; tick();
      chk("ei_fetch2", 32'(ime), 32'd1);
      clr(); di = 1'b1; tick();
      clr(); ei = 1'b1; tick();
      clr(); di = 1'b1; tick();
      clr(); fetch = 1'b1; tick();
      clr(); fetch = 1'b1; tick();
      chk("ei_di", 32'(ime), 32'd0);
      clr(); ei = 1'b1; tick();
      clr(); fetch = 1'b1; tick();
      clr(); fetch = 1'b1; di = 1'b1; tick();
      chk("ei_di_same_step", 32'(ime), 32'd0);

      // cancel: IE cleared during WAIT2
      do_reset();
      wr(1'b1, 8'h1F);
      clr(); reti = 1'b1; irq = 5'b00100; tick();
      clr(); int_ack = 1'b1; tick();
      idle(1);
      wr(1'b1, 8'h00);
      idle(2);
      chk("cancel_lv", 32'(load_vec), 32'd1);
      chk("cancel_bro", 32'(bro), 32'd0);
      chk("cancel_ime", 32'(ime), 32'd0);
      rd(1'b0);
      chk("cancel_if", 32'(DL_out), 32'hE4);

      // reprioritise: VBlank arrives during WAIT1 of a Joypad dispatch
      do_reset();
      wr(1'b1, 8'h1F);
      wr(1'b0, 8'h10);
      clr(); reti = 1'b1; tick();
      clr(); int_ack = 1'b1; tick();
      clr(); irq = 5'b00001; tick();
      idle(3);
      chk("reprio_bro", 32'(bro), 32'h08);
      rd(1'b0);
      chk("reprio_if", 32'(DL_out), 32'hF0);

      // reset during PUSH_L
      do_reset();
      wr(1'b0, 8'h1F);
      wr(1'b1, 8'hFF);
      clr(); reti = 1'b1; tick();
      clr(); int_ack = 1'b1; tick();
      idle(3);
      chk("rst_in_push_l", 32'(push_l), 32'd1);
      clr(); nRES = 1'b0; tick();
      chk("rst_int_req", 32'(int_req), 32'd0);
      chk("rst_halt", 32'(halt_wake), 32'd0);
      chk("rst_push", 32'({push_h, push_l, load_vec}), 32'd0);
      chk("rst_busy", 32'(dsp_busy), 32'd0);
      chk("rst_bro", 32'(bro), 32'd0);
      chk("rst_dl", 32'(DL_out), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);
      rd(1'b0);
      chk("rst_if", 32'(DL_out), 32'hE0);

      // randomized traffic against the model
      for (int n = 0; n < 2000; n++) begin
         nRES    = ($urandom_range(199) != 0);
         mstep   = ($urandom_range(3) != 0);
         irq     = ($urandom_range(5) == 0) ? 5'($urandom) : 5'h00;
         reg_wr  = ($urandom_range(11) == 0);
         reg_sel = 1'($urandom);
         reg_rd  = 1'($urandom);
         DL_in   = 8'($urandom);
         ei      = ($urandom_range(15) == 0);
         di      = ($urandom_range(24) == 0);
         reti    = ($urandom_range(9) == 0);
         fetch   = ($urandom_range(1) == 0);
         int_ack = 1'($urandom);
         tick();
      end
      idle(8);
      chk("sb_drain", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/irq_dispatch.md
# irq_dispatch

Interrupt flag/enable unit and dispatch sequencer for the SM83 core. It latches peripheral interrupt requests into IF and holds the IE mask and the IME master enable, including the delayed EI semantics. It runs the 5 M-cycle interrupt dispatch sequence and supplies the vector bits `bro[7:3]` consumed by the PC input mux, plus push strobes for the sequencer.

## Interface
Parameters:
- `NIRQ`, 5: number of interrupt sources (VBlank, STAT, Timer, Serial, Joypad; index 0 = highest priority).

Ports:
- `CLK` in 1: single clock, all state updates on rising edge.
- `nRES` in 1: reset, synchronous, active-low.
- `mstep` in 1: M-cycle advance enable; FSM and IME logic advance only when high.
- `irq` in NIRQ: request pulses from peripherals; sampled every clock.
- `reg_wr` in 1: register write strobe.
- `reg_rd` in 1: register read enable.
- `reg_sel` in 1: 0 = IF (FF0F), 1 = IE (FFFF).
- `DL_in` in 8: write data from internal databus.
- `DL_out` out 8: read data.
- `ei`, `di`, `reti` in 1 each: instruction-decode strobes, one clock, qualified by `mstep`.
- `fetch` in 1: instruction-boundary (opcode fetch) strobe, qualified by `mstep`.
- `int_ack` in 1: sequencer accepts `int_req` at an instruction boundary.
- `int_req` out 1: interrupt pending and dispatchable.
- `halt_wake` out 1: any enabled request pending, regardless of IME.
- `ime` out 1: master enable.
- `dsp_busy` out 1: dispatch FSM not idle.
- `push_h`, `push_l` out 1 each: sequencer pushes PCH / PCL this M-cycle.
- `load_vec` out 1: PC loads the vector this M-cycle.
- `bro` out [7:3]: vector bits to PC mux; zero when `load_vec` is low.

## Operation
- IF: 5-bit register. Set bit n on `irq[n]`. Write (`reg_wr`, `reg_sel`=0) loads `DL_in[4:0]`. Priority within one clock: write value, then dispatch clear, then OR of `irq`. A request always survives a simultaneous write or clear.
- IE: 8-bit register, fully read/write. Bits [7:5] are stored but never dispatch.
- Reads:
  - `DL_out` = {3'b111, IF} when `reg_rd` and `reg_sel`=0.
  - `DL_out` = IE when `reg_rd` and `reg_sel`=1.
  - `DL_out` = 8'h00 otherwise.
- `pend` = IF & IE[4:0]. `halt_wake` = |`pend`. `int_req` = `ime` & |`pend` & state IDLE & !`ei_pend`-window rule below.
- IME:
  - `di` clears IME and `ei_pend`.
  - `reti` sets IME immediately.
  - `ei` sets `ei_pend`. IME becomes 1 on the first `fetch` after the one that ends the EI instruction; the instruction after EI always runs before any dispatch.
  - `di` in the same step as a pending promotion wins, leaving IME at 0.
- FSM states: IDLE, WAIT1, WAIT2, PUSH_H, PUSH_L, JUMP. Each transition requires `mstep`.
  - IDLE→WAIT1 on `int_ack` & `int_req`; IME cleared in the same step.
  - WAIT1→WAIT2→PUSH_H→PUSH_L→JUMP→IDLE unconditionally.
- Vector selection happens at the end of PUSH_H: the lowest-index set bit of `pend` is latched as `vsel`, with `vvalid`=|`pend`. This models the IE-write-during-push cancel.
- JUMP with `vvalid`=1: `bro` = {2'b01, vsel[2:0]}, giving vectors 0x40/48/50/58/60, and IF[vsel] is cleared.
- JUMP with `vvalid`=0: `bro` = 0 (vector 0x0000) and IF is unchanged.
- Output decode: `push_h`, `push_l` and `load_vec` are high exactly in PUSH_H, PUSH_L and JUMP respectively. `dsp_busy` = state≠IDLE.

## Timing
- Reset (`nRES`=0 at edge): IF=0, IE=0, IME=0, `ei_pend`=0, state IDLE, `vsel`=0, `vvalid`=0. Resulting outputs: `int_req`, `halt_wake`, `push_*`, `load_vec`, `dsp_busy` all 0; `bro`=0; `DL_out`=0. This holds mid-dispatch: the FSM aborts to IDLE with no further push or load strobes.
- Dispatch latency: `int_ack` step to `load_vec` is 4 further `mstep`s, giving a 5 M-cycle total. With `mstep` tied high this is 5 clocks.
- Request-to-visibility: `irq` at edge k sets IF at edge k; `int_req` and `halt_wake` are high from edge k.
- `mstep`=0 freezes the FSM, IME and `ei_pend`. IF and IE writes and `irq` capture are not gated by `mstep`.
- Register write followed by read: value is visible on the next clock.

## Test plan
- Reset: preload IF=1F, IE=FF, start a dispatch, drop `nRES` in PUSH_L → next clock all outputs 0, state IDLE, IF read = E0.
- Priority: IE=1F, IME=1, pulse `irq`=5'b10100, `int_ack` → `load_vec` 4 steps later with `bro`=01010 (0x50); IF then reads E0|10.
- EI delay: IME=0, `ei`, then `fetch` → `ime`=0; second `fetch` → `ime`=1. `ei` then `di` → `ime` stays 0.
- Cancel: dispatch for Timer, write IE=00 during WAIT2 → `bro`=00000 at JUMP, IF bit 2 still set, IME=0.
- Cancel reprioritise: dispatch for Joypad (IF=10), raise `irq[0]` during WAIT1 → `bro`=01000 (0x40), only IF bit 0 cleared.
- Collision: `irq[1]` in the same clock as an IF write of 00 → IF reads E2; with IME=0 and IE[1]=1, `halt_wake`=1 and `int_req`=0.
